// File: rtl/dmem_responder.sv
// dmem_responder
//
// Multi-cycle data-memory slave behind the CPU load/store port. A request
// is accepted only while idle and held for LATENCY wait states. On the last
// wait-state edge the access is performed: a byte-masked store, or a load
// into a registered read word. The response is then presented for exactly
// one cycle. busy_o is meant to stall the pipeline for the whole
// transaction.
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit storage words (>= 1)
//   LATENCY     - wait-state cycles between accept and response (>= 1)
//
// Ports:
//   clk_i   - clock, rising edge active
//   rst_i   - asynchronous active-low reset
//   req_i   - request strobe, sampled only while idle
//   we_i    - 1 = store, 0 = load
//   addr_i  - byte address; the word index is addr_i[31:2]
//   wdata_i - store data
//   be_i    - store byte enables, bit n writes lane [8n+7:8n]
//   busy_o  - a request is in flight (WAIT or RESP)
//   ack_o   - one-cycle response strobe
//   rdata_o - load data, qualified by ack_o
//   err_o   - misaligned or out-of-range access, qualified by ack_o

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD    = CW'(LATENCY - 1);
    localparam logic [30:0]   DEPTH_LIMIT = 31'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q;
    state_t          next_state;
    logic [CW-1:0]   cnt_q;

    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            err_q;

    logic [31:0]     rdata_q;
    logic            err_out_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            commit;
    logic            req_err;

    // The error decision is made from the request as presented at accept,
    // so later changes on addr_i cannot affect the response.
    assign req_err = (addr_i[1:0] != 2'b00) ||
                     ({1'b0, addr_i[31:2]} >= DEPTH_LIMIT);

    assign accept = (state_q == IDLE) && req_i;
    assign commit = (state_q == WAIT) && (cnt_q == '0);

    // Next-state decode. RESP always returns to IDLE, so a request held
    // high is picked up one cycle after the ack.
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (req_i)         next_state = WAIT;
            WAIT:    if (cnt_q == '0)   next_state = RESP;
            RESP:                       next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    // Control and response registers. Reset is asynchronous so a reset in
    // WAIT forces IDLE before the commit edge, which drops the store.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            err_out_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (accept) begin
                we_q    <= we_i;
                idx_q   <= addr_i[AW+1:2];
                wdata_q <= wdata_i;
                be_q    <= be_i;
                err_q   <= req_err;
                cnt_q   <= CNT_LOAD;
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (commit) begin
                err_out_q <= err_q;
                rdata_q   <= (err_q || we_q) ? 32'h0 : mem[idx_q];
            end
        end
    end

    // Storage is deliberately not reset. A write can only happen in WAIT,
    // which an asserted reset has already left.
    always_ff @(posedge clk_i) begin
        if (commit && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign ack_o   = (state_q == RESP);
    assign rdata_o = rdata_q;
    assign err_o   = err_out_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//
// Directed bench for dmem_responder. Instance dut_a runs with LATENCY=2 and
// a vector table of stores and loads. Instance dut_b runs with LATENCY=1
// for back-to-back requests with req held high. Both instances share the
// clock and reset.
//
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.

module tb_dmem_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 11;

    logic        clk_i = 1'b0;
    logic        rst_i;

    logic        req_a, we_a;
    logic [31:0] addr_a, wdata_a;
    logic [3:0]  be_a;
    logic        busy_a, ack_a, err_a;
    logic [31:0] rdata_a;

    logic        req_b, we_b;
    logic [31:0] addr_b, wdata_b;
    logic [3:0]  be_b;
    logic        busy_b, ack_b, err_b;
    logic [31:0] rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [NVEC];
    vec_t v;

    always #5 clk_i = ~clk_i;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_a),
        .we_i    (we_a),
        .addr_i  (addr_a),
        .wdata_i (wdata_a),
        .be_i    (be_a),
        .busy_o  (busy_a),
        .ack_o   (ack_a),
        .rdata_o (rdata_a),
        .err_o   (err_a)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_b),
        .we_i    (we_b),
        .addr_i  (addr_b),
        .wdata_i (wdata_b),
        .be_i    (be_b),
        .busy_o  (busy_b),
        .ack_o   (ack_b),
        .rdata_o (rdata_b),
        .err_o   (err_b)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One request on dut_a (LATENCY=2). Called at the falling edge of cycle 0.
    // It returns at the falling edge of cycle 4, which is the next cycle 0.
    // Inputs are scrambled during WAIT to show that only the accept-time
    // values matter.
    task automatic apply_stimulus(input vec_t t, input string tag);
        req_a   = 1'b1;
        we_a    = t.we;
        addr_a  = t.addr;
        wdata_a = t.wdata;
        be_a    = t.be;
        @(negedge clk_i);
        check_output({tag, " c1 busy"}, 32'(busy_a), 32'd1);
        check_output({tag, " c1 ack"},  32'(ack_a),  32'd0);
        req_a   = 1'b0;
        we_a    = ~t.we;
        addr_a  = 32'hFFFF_FFFF;
        wdata_a = ~t.wdata;
        be_a    = ~t.be;
        @(negedge clk_i);
        check_output({tag, " c2 busy"}, 32'(busy_a), 32'd1);
        check_output({tag, " c2 ack"},  32'(ack_a),  32'd0);
        @(negedge clk_i);
        check_output({tag, " c3 ack"},   32'(ack_a),  32'd1);
        check_output({tag, " c3 busy"},  32'(busy_a), 32'd1);
        check_output({tag, " c3 err"},   32'(err_a),  32'(t.exp_err));
        check_output({tag, " c3 rdata"}, rdata_a,     t.exp_rdata);
        @(negedge clk_i);
        check_output({tag, " c4 busy"}, 32'(busy_a), 32'd0);
        check_output({tag, " c4 ack"},  32'(ack_a),  32'd0);
    endtask

    // One request on dut_b (LATENCY=1). Called at cycle 0, returns at cycle 3.
    task automatic apply_stimulus_b(input vec_t t, input string tag);
        req_b   = 1'b1;
        we_b    = t.we;
        addr_b  = t.addr;
        wdata_b = t.wdata;
        be_b    = t.be;
        @(negedge clk_i);
        check_output({tag, " c1 busy"}, 32'(busy_b), 32'd1);
        check_output({tag, " c1 ack"},  32'(ack_b),  32'd0);
        req_b = 1'b0;
        @(negedge clk_i);
        check_output({tag, " c2 ack"},   32'(ack_b), 32'd1);
        check_output({tag, " c2 err"},   32'(err_b), 32'(t.exp_err));
        check_output({tag, " c2 rdata"}, rdata_b,    t.exp_rdata);
        @(negedge clk_i);
        check_output({tag, " c3 busy"}, 32'(busy_b), 32'd0);
    endtask

    initial begin
        // Fields: we, addr, wdata, be, exp_err, exp_rdata.
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 32'hDE22_BE44};
        vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0000};
        vecs[5]  = '{1'b1, 32'h0000_0400, 32'h5555_AAAA, 4'b1111, 1'b1, 32'h0000_0000};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 32'hDE22_BE44};
        vecs[7]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0000_0000};
        vecs[8]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'b0000, 1'b0, 32'hCAFE_F00D};

        rst_i   = 1'b0;
        req_a   = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = '0;
        req_b   = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0;

        #2;
        check_output("reset busy",  32'(busy_a), 32'd0);
        check_output("reset ack",   32'(ack_a),  32'd0);
        check_output("reset err",   32'(err_a),  32'd0);
        check_output("reset rdata", rdata_a,     32'd0);
        check_output("reset busy b", 32'(busy_b), 32'd0);

        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check_output("idle no req busy", 32'(busy_a), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Store to 0x10, then reset in the last WAIT cycle before the commit
        // edge. The store must be dropped and outputs must clear at once.
        req_a   = 1'b1;
        we_a    = 1'b1;
        addr_a  = 32'h0000_0010;
        wdata_a = 32'h0000_0000;
        be_a    = 4'b1111;
        @(negedge clk_i);
        req_a = 1'b0;
        @(negedge clk_i);
        check_output("rst pre busy", 32'(busy_a), 32'd1);
        rst_i = 1'b0;
        #1;
        check_output("rst mid busy",  32'(busy_a), 32'd0);
        check_output("rst mid ack",   32'(ack_a),  32'd0);
        check_output("rst mid err",   32'(err_a),  32'd0);
        check_output("rst mid rdata", rdata_a,     32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_output("post rst busy", 32'(busy_a), 32'd0);
        check_output("post rst ack",  32'(ack_a),  32'd0);
        v = '{1'b0, 32'h0000_0010, 32'h0, 4'b0000, 1'b0, 32'hDE22_BE44};
        apply_stimulus(v, "reload after rst");

        // dut_b: seed two words, then two loads with req held high.
        v = '{1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'b1111, 1'b0, 32'h0};
        apply_stimulus_b(v, "b store20");
        v = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'b1111, 1'b0, 32'h0};
        apply_stimulus_b(v, "b store24");

        req_b  = 1'b1;
        we_b   = 1'b0;
        addr_b = 32'h0000_0020;
        be_b   = 4'b0000;
        @(negedge clk_i);
        check_output("b2b c1 busy", 32'(busy_b), 32'd1);
        check_output("b2b c1 ack",  32'(ack_b),  32'd0);
        addr_b = 32'h0000_0024;
        @(negedge clk_i);
        check_output("b2b c2 ack",   32'(ack_b),  32'd1);
        check_output("b2b c2 busy",  32'(busy_b), 32'd1);
        check_output("b2b c2 rdata", rdata_b,     32'hA5A5_0F0F);
        @(negedge clk_i);
        check_output("b2b c3 busy", 32'(busy_b), 32'd0);
        check_output("b2b c3 ack",  32'(ack_b),  32'd0);
        @(negedge clk_i);
        check_output("b2b c4 busy", 32'(busy_b), 32'd1);
        check_output("b2b c4 ack",  32'(ack_b),  32'd0);
        @(negedge clk_i);
        check_output("b2b c5 ack",   32'(ack_b),  32'd1);
        check_output("b2b c5 busy",  32'(busy_b), 32'd1);
        check_output("b2b c5 rdata", rdata_b,     32'h1234_5678);
        check_output("b2b c5 err",   32'(err_b),  32'd0);
        req_b = 1'b0;
        @(negedge clk_i);
        check_output("b2b c6 busy", 32'(busy_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
